cn_job_sequencer: RTL and testbench

//  Host-side job sequencer for the cn_top CryptoNight main-loop core. Per job: streams 28 h0 words
//  and 140 random-math code words into cn_top's reg port, optionally pattern-fills the scratchpad
//  via the mem port, then pulses start, waits for sts_ml_finished (with timeout) and reports status.

---
 rtl/cn_seq_pkg.sv | 35 +++
 rtl/cn_scratch_fill.sv | 62 ++++++
 rtl/cn_job_sequencer.sv | 169 ++++++++++++++++
 tb/tb_cn_job_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cn_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cn_seq_pkg                                                               |
// | Shared state encoding, job geometry and status codes for cn_job_sequencer |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package cn_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_H0   = 3'd1,
    LOAD_CODE = 3'd2,
    FILL      = 3'd3,
    START     = 3'd4,
    RUN       = 3'd5,
    STOP      = 3'd6,
    DONE      = 3'd7
  } seq_state_t;

  localparam int unsigned H0_WORDS   = 28;
  localparam int unsigned CODE_WORDS = 140;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_ABORTED = 2'd2;

  // Scratchpad fill word k: upper lane 2k+1, lower lane 2k.
  function automatic logic [127:0] fill_pattern(input logic [31:0] k);
    logic [63:0] even;
    even = {31'd0, k, 1'b0};
    return {even | 64'd1, even};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cn_scratch_fill.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cn_scratch_fill                                                          |
// | Sweeps the whole cn_top scratchpad, one pattern word per cycle.          |
// | Used only when CN_SCRATCH_FILL_EN is defined. Revision: 1.0              |
// +--------------------------------------------------------------------------+
module cn_scratch_fill
  import cn_seq_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 15
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     clear,
  output logic                     busy,
  output logic                     last,
  output logic [ADDRESS_WIDTH+1:0] mem_address,
  output logic                     mem_write,
  output logic [127:0]             mem_wrdata
);

  localparam int unsigned AW = ADDRESS_WIDTH + 2;

  logic          r_busy;
  logic [AW-1:0] r_k;
  logic [AW-1:0] r_mem_address;
  logic          r_mem_write;
  logic [127:0]  r_mem_wrdata;

  assign busy        = r_busy;
  assign last        = r_busy && (r_k == {AW{1'b1}});
  assign mem_address = r_mem_address;
  assign mem_write   = r_mem_write;
  assign mem_wrdata  = r_mem_wrdata;

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_busy        <= 1'b0;
      r_k           <= '0;
      r_mem_address <= '0;
      r_mem_write   <= 1'b0;
      r_mem_wrdata  <= '0;
    end else begin
      r_mem_write <= 1'b0;
      if (clear) begin
        r_busy <= 1'b0;
      end else if (start) begin
        r_busy <= 1'b1;
        r_k    <= '0;
      end else if (r_busy) begin
        r_mem_write   <= 1'b1;
        r_mem_address <= r_k;
        r_mem_wrdata  <= fill_pattern(32'(r_k));
        r_k           <= r_k + 1'b1;
        if (last) r_busy <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cn_job_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cn_job_sequencer                                                         |
// | Loads h0/code into cn_top, optionally fills scratchpad (macro            |
// | CN_SCRATCH_FILL_EN), starts the main loop and reports status. Rev 1.0    |
// +--------------------------------------------------------------------------+
module cn_job_sequencer
  import cn_seq_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = 15,
  parameter logic [9:0]  H0_BASE        = 10'h100,
  parameter logic [9:0]  CODE_BASE      = 10'h000,
  parameter logic [9:0]  CNTL_BASE      = 10'h200,
  parameter int unsigned TIMEOUT_CYCLES = 32'd16777216
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic                     abort,
  input  logic [31:0]              src_data,
  input  logic                     src_valid,
  output logic                     src_ready,
  output logic [9:0]               reg_address,
  output logic                     reg_write,
  output logic [31:0]              reg_wrdata,
  output logic [ADDRESS_WIDTH+1:0] mem_address,
  output logic                     mem_write,
  output logic [127:0]             mem_wrdata,
  input  logic                     sts_ml_finished,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               done_status
);

  seq_state_t  r_state, w_next;
  logic [7:0]  r_idx;
  logic [31:0] r_timer;
  logic        r_fin_q;
  logic [1:0]  r_status, w_status_d, r_done_status;
  logic        r_reg_write;
  logic [9:0]  r_reg_address;
  logic [31:0] r_reg_wrdata;
  logic        w_beat, w_rise, w_abortable, w_h0_last, w_code_last, w_timeout;

  assign job_ready   = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign done_status = r_done_status;
  assign reg_write   = r_reg_write;
  assign reg_address = r_reg_address;
  assign reg_wrdata  = r_reg_wrdata;

  // Abort masks the beat so a word arriving with abort is never written.
  assign src_ready   = ((r_state == LOAD_H0) || (r_state == LOAD_CODE)) && !abort;
  assign w_beat      = src_ready && src_valid;
  assign w_h0_last   = (r_state == LOAD_H0) && (r_idx == 8'(H0_WORDS - 1));
  assign w_code_last = (r_state == LOAD_CODE) && (r_idx == 8'(CODE_WORDS - 1));
  assign w_rise      = sts_ml_finished && !r_fin_q;
  assign w_timeout   = (r_timer == 32'(TIMEOUT_CYCLES - 1));
  assign w_abortable = (r_state != IDLE) && (r_state != STOP) && (r_state != DONE);

`ifdef CN_SCRATCH_FILL_EN
  logic w_fill_start, w_fill_last, w_fill_busy, w_fill_clear;

  assign w_fill_clear = abort && (r_state == FILL);

  cn_scratch_fill #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_fill (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (w_fill_start),
    .clear      (w_fill_clear),
    .busy       (w_fill_busy),
    .last       (w_fill_last),
    .mem_address(mem_address),
    .mem_write  (mem_write),
    .mem_wrdata (mem_wrdata)
  );
`else
  assign mem_address = '0;
  assign mem_write   = 1'b0;
  assign mem_wrdata  = '0;
`endif

  always_comb begin
    w_next     = r_state;
    w_status_d = r_status;
`ifdef CN_SCRATCH_FILL_EN
    w_fill_start = 1'b0;
`endif
    case (r_state)
      IDLE:      if (job_valid) w_next = LOAD_H0;
      LOAD_H0:   if (w_beat && w_h0_last) w_next = LOAD_CODE;
      LOAD_CODE: if (w_beat && w_code_last) begin
`ifdef CN_SCRATCH_FILL_EN
        w_next       = FILL;
        w_fill_start = 1'b1;
`else
        w_next = START;
`endif
      end
`ifdef CN_SCRATCH_FILL_EN
      FILL:      if (w_fill_last || !w_fill_busy) w_next = START;
`endif
      START:     w_next = RUN;
      RUN: begin
        // A finish edge beats a coincident timeout.
        if (w_rise) begin
          w_next     = DONE;
          w_status_d = ST_OK;
        end else if (w_timeout) begin
          w_next     = STOP;
          w_status_d = ST_TIMEOUT;
        end
      end
      STOP:      w_next = DONE;
      DONE:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
    if (abort && w_abortable) begin
      w_next     = STOP;
      w_status_d = ST_ABORTED;
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_timer       <= '0;
      r_fin_q       <= 1'b0;
      r_status      <= ST_OK;
      r_done_status <= ST_OK;
      r_reg_write   <= 1'b0;
      r_reg_address <= '0;
      r_reg_wrdata  <= '0;
    end else begin
      r_state  <= w_next;
      r_fin_q  <= sts_ml_finished;
      r_status <= w_status_d;
      if ((w_next == DONE) && (r_state != DONE)) r_done_status <= w_status_d;

      if (r_state == IDLE)  r_idx <= '0;
      else if (w_beat)      r_idx <= (w_h0_last || w_code_last) ? 8'd0 : 8'(r_idx + 8'd1);

      if (r_state == START)    r_timer <= '0;
      else if (r_state == RUN) r_timer <= r_timer + 32'd1;

      r_reg_write <= 1'b0;
      if (w_beat) begin
        r_reg_write   <= 1'b1;
        r_reg_address <= ((r_state == LOAD_H0) ? H0_BASE : CODE_BASE) + {2'b00, r_idx};
        r_reg_wrdata  <= src_data;
      end else if ((r_state == START) && (w_next == RUN)) begin
        r_reg_write   <= 1'b1;
        r_reg_address <= CNTL_BASE;
        r_reg_wrdata  <= 32'd1;
      end else if (r_state == STOP) begin
        r_reg_write   <= 1'b1;
        r_reg_address <= CNTL_BASE;
        r_reg_wrdata  <= 32'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cn_job_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cn_job_sequencer                                                      |
// | Directed bench; dut_a runs normal jobs, dut_b has a 64-cycle timeout.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_cn_job_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, job_valid_a, job_valid_b, abort, src_valid, fin, sel;
  logic [31:0] src_data;

  logic         job_ready_a, src_ready_a, reg_write_a, mem_write_a, busy_a, done_a;
  logic         job_ready_b, src_ready_b, reg_write_b, mem_write_b, busy_b, done_b;
  logic [9:0]   reg_address_a, reg_address_b;
  logic [31:0]  reg_wrdata_a, reg_wrdata_b;
  logic [4:0]   mem_address_a, mem_address_b;
  logic [127:0] mem_wrdata_a, mem_wrdata_b;
  logic [1:0]   done_status_a, done_status_b;

  cn_job_sequencer #(.ADDRESS_WIDTH(3), .TIMEOUT_CYCLES(2000)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .job_valid(job_valid_a), .job_ready(job_ready_a),
    .abort(abort), .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready_a),
    .reg_address(reg_address_a), .reg_write(reg_write_a), .reg_wrdata(reg_wrdata_a),
    .mem_address(mem_address_a), .mem_write(mem_write_a), .mem_wrdata(mem_wrdata_a),
    .sts_ml_finished(fin), .busy(busy_a), .done(done_a), .done_status(done_status_a));

  cn_job_sequencer #(.ADDRESS_WIDTH(3), .TIMEOUT_CYCLES(64)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .job_valid(job_valid_b), .job_ready(job_ready_b),
    .abort(abort), .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready_b),
    .reg_address(reg_address_b), .reg_write(reg_write_b), .reg_wrdata(reg_wrdata_b),
    .mem_address(mem_address_b), .mem_write(mem_write_b), .mem_wrdata(mem_wrdata_b),
    .sts_ml_finished(fin), .busy(busy_b), .done(done_b), .done_status(done_status_b));

  wire         m_src_ready = sel ? src_ready_b : src_ready_a;
  wire         m_reg_write = sel ? reg_write_b : reg_write_a;
  wire [9:0]   m_reg_addr  = sel ? reg_address_b : reg_address_a;
  wire [31:0]  m_reg_data  = sel ? reg_wrdata_b : reg_wrdata_a;
  wire         m_mem_write = sel ? mem_write_b : mem_write_a;
  wire [4:0]   m_mem_addr  = sel ? mem_address_b : mem_address_a;
  wire [127:0] m_mem_data  = sel ? mem_wrdata_b : mem_wrdata_a;
  wire         m_done      = sel ? done_b : done_a;
  wire [1:0]   m_done_st   = sel ? done_status_b : done_status_a;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [9:0]   wa[$];
  logic [31:0]  wd[$];
  int           wc[$];
  logic [4:0]   ma[$];
  logic [127:0] md[$];
  int           mc[$];
  int           done_cnt, done_cyc;
  logic [1:0]   done_st;
  int           checks = 0;
  int           failures = 0;

  always @(negedge clk) begin
    if (m_reg_write) begin wa.push_back(m_reg_addr); wd.push_back(m_reg_data); wc.push_back(cyc); end
    if (m_mem_write) begin ma.push_back(m_mem_addr); md.push_back(m_mem_data); mc.push_back(cyc); end
    if (m_done) begin done_cnt++; done_cyc = cyc; done_st = m_done_st; end
  end

  task automatic clear_mon();
    wa.delete(); wd.delete(); wc.delete(); ma.delete(); md.delete(); mc.delete();
    done_cnt = 0; done_cyc = -1; done_st = 2'b11;
  endtask

  function automatic int find_w(input logic [9:0] a, input logic [31:0] d);
    for (int i = 0; i < wa.size(); i++) if (wa[i] == a && wd[i] == d) return i;
    return -1;
  endfunction

  task automatic launch();
    @(negedge clk);
    if (sel) job_valid_b = 1'b1; else job_valid_a = 1'b1;
    @(negedge clk);
    job_valid_a = 1'b0; job_valid_b = 1'b0;
  endtask

  // Drives n words; the word at index abort_at is presented together with abort.
  task automatic feed(input int n, input bit toggle, input int abort_at, output int acc0);
    int  i = 0;
    int  guard = 0;
    bit  ph = 1'b1;
    bit  acc;
    acc0 = -1;
    while (i < n && guard < 2000) begin
      @(negedge clk);
      guard++;
      src_data  = 32'hA500_0000 + 32'(i);
      src_valid = toggle ? ph : 1'b1;
      ph = ~ph;
      if (i == abort_at) abort = 1'b1;
      #1;
      acc = src_valid && m_src_ready;
      @(posedge clk); #1;
      if (i == abort_at) begin abort = 1'b0; break; end
      if (acc) begin if (i == 0) acc0 = cyc; i++; end
    end
    src_valid = 1'b0;
    if (abort_at < 0) begin
      checks++;
      if (i != n) begin failures++; $display("FAIL feed_words accepted=%0d required=%0d", i, n); end
    end
  endtask

  task automatic wait_write(input logic [31:0] d, input int max, output int at);
    int g = 0;
    while (find_w(10'h200, d) < 0 && g < max) begin @(negedge clk); g++; end
    @(negedge clk);
    at = find_w(10'h200, d);
    checks++;
    if (at < 0) begin failures++; $display("FAIL cntl_write_%0d actual=absent required=present", d); end
    else at = wc[at];
  endtask

  task automatic wait_done(input int max);
    int g = 0;
    while (done_cnt == 0 && g < max) begin @(negedge clk); g++; end
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL done_seen actual=%0d required=1", done_cnt); end
  endtask

  task automatic check_loads(input string name, input int n);
    int bad = -1;
    for (int i = 0; i < n; i++) begin
      logic [9:0] ea;
      ea = (i < 28) ? 10'(10'h100 + i) : 10'(i - 28);
      if (i >= wa.size() || wa[i] !== ea || wd[i] !== 32'hA500_0000 + 32'(i)) begin bad = i; break; end
    end
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s index=%0d actual_addr=%h actual_data=%h size=%0d required_addr=%h",
               name, bad, (bad < wa.size()) ? wa[bad] : 10'h3ff, (bad < wd.size()) ? wd[bad] : 32'h0,
               wa.size(), (bad < 28) ? 10'(10'h100 + bad) : 10'(bad - 28));
    end
  endtask

  task automatic finish_job();
    int fc;
    repeat (5) @(negedge clk);
    fin = 1'b1; fc = cyc;
    wait_done(20);
    checks++;
    if (done_cyc != fc + 1 || done_st !== 2'd0) begin
      failures++; $display("FAIL finish_ok done_cyc=%0d status=%0d required_cyc=%0d status=0", done_cyc, done_st, fc + 1);
    end
    @(negedge clk); fin = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b1; job_valid_a = 0; job_valid_b = 0; abort = 0; src_valid = 0; src_data = 0; fin = 0; sel = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (job_ready_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0 || src_ready_a !== 1'b0) begin
      failures++; $display("FAIL reset_handshake ready=%b busy=%b done=%b src_ready=%b required=1000",
                           job_ready_a, busy_a, done_a, src_ready_a);
    end
    checks++;
    if (reg_write_a !== 1'b0 || reg_address_a !== 10'd0 || reg_wrdata_a !== 32'd0 || mem_write_a !== 1'b0) begin
      failures++; $display("FAIL reset_ports write=%b addr=%h data=%h mem_write=%b required=0", reg_write_a,
                           reg_address_a, reg_wrdata_a, mem_write_a);
    end
    checks++;
    if (done_status_a !== 2'd0) begin failures++; $display("FAIL reset_status actual=%0d required=0", done_status_a); end
  endtask

  task automatic test_back_to_back();
    int acc0, sc, fc;
    sel = 0; clear_mon();
    launch();
    feed(168, 1'b0, -1, acc0);
    wait_write(32'd1, 50, sc);
    checks++;
    if (wc.size() == 0 || wc[0] != acc0) begin
      failures++; $display("FAIL first_write_latency actual_cyc=%0d required_cyc=%0d", (wc.size() > 0) ? wc[0] : -1, acc0);
    end
    check_loads("b2b_loads", 168);
    checks++;
    if (wa.size() != 169) begin failures++; $display("FAIL b2b_write_count actual=%0d required=169", wa.size()); end
    repeat (100) @(negedge clk);
    fin = 1'b1; fc = cyc;
    wait_done(20);
    checks++;
    if (done_cyc != fc + 1 || done_st !== 2'd0) begin
      failures++; $display("FAIL b2b_done cyc=%0d status=%0d required_cyc=%0d status=0", done_cyc, done_st, fc + 1);
    end
    @(negedge clk); fin = 1'b0;
    checks++;
    if (find_w(10'h200, 32'd0) >= 0 || done_a !== 1'b0 || job_ready_a !== 1'b1) begin
      failures++; $display("FAIL b2b_end stop_write=%0d done=%b ready=%b required=-1,0,1", find_w(10'h200, 32'd0), done_a, job_ready_a);
    end
`ifndef CN_SCRATCH_FILL_EN
    checks++;
    if (ma.size() != 0) begin failures++; $display("FAIL mem_tied_off actual=%0d required=0", ma.size()); end
`endif
  endtask

  task automatic test_src_toggle();
    int acc0, sc;
    sel = 0; clear_mon();
    launch();
    feed(168, 1'b1, -1, acc0);
    wait_write(32'd1, 50, sc);
    check_loads("toggle_loads", 168);
    checks++;
    if (wa.size() != 169) begin failures++; $display("FAIL toggle_write_count actual=%0d required=169", wa.size()); end
    finish_job();
  endtask

`ifdef CN_SCRATCH_FILL_EN
  task automatic test_scratch_fill();
    int acc0, sc, bad;
    sel = 0; clear_mon();
    launch();
    feed(168, 1'b0, -1, acc0);
    wait_write(32'd1, 80, sc);
    checks++;
    if (ma.size() != 32) begin failures++; $display("FAIL fill_count actual=%0d required=32", ma.size()); end
    checks++;
    if (ma.size() > 5 && md[5] !== {64'd11, 64'd10}) begin
      failures++; $display("FAIL fill_word5 actual=%h required=%h", md[5], {64'd11, 64'd10});
    end
    bad = -1;
    for (int k = 0; k < ma.size(); k++)
      if (ma[k] !== 5'(k) || md[k] !== {64'(2 * k + 1), 64'(2 * k)}) begin bad = k; break; end
    checks++;
    if (bad >= 0) begin failures++; $display("FAIL fill_pattern index=%0d actual_addr=%0d actual_data=%h", bad, ma[bad], md[bad]); end
    checks++;
    if (ma.size() != 32 || mc[0] != wc[167] + 1 || sc != mc[31] + 1) begin
      failures++; $display("FAIL fill_order first_mem=%0d last_code=%0d start=%0d last_mem=%0d",
                           (mc.size() > 0) ? mc[0] : -1, wc[167], sc, (mc.size() > 0) ? mc[mc.size() - 1] : -1);
    end
    finish_job();
  endtask
`endif

  task automatic test_timeout();
    int acc0, sc, pc;
    sel = 1; clear_mon();
    launch();
    feed(168, 1'b0, -1, acc0);
    wait_write(32'd1, 80, sc);
    wait_done(200);
    pc = find_w(10'h200, 32'd0);
    checks++;
    // RUN spans timer 0..63, STOP issues the write, which lands one cycle later.
    if (pc < 0 || wc[pc] != sc + 65) begin
      failures++; $display("FAIL timeout_stop_cyc actual=%0d required=%0d", (pc >= 0) ? wc[pc] : -1, sc + 65);
    end
    checks++;
    if (done_st !== 2'd1 || (pc >= 0 && done_cyc != wc[pc])) begin
      failures++; $display("FAIL timeout_done status=%0d cyc=%0d required status=1", done_st, done_cyc);
    end
    @(negedge clk); sel = 0;
  endtask

  task automatic test_abort();
    int acc0;
    sel = 0; clear_mon();
    launch();
    feed(168, 1'b0, 78, acc0);
    wait_done(20);
    checks++;
    if (wa.size() != 79) begin failures++; $display("FAIL abort_write_count actual=%0d required=79", wa.size()); end
    check_loads("abort_loads", 78);
    checks++;
    if (wa.size() < 79 || wa[78] !== 10'h200 || wd[78] !== 32'd0) begin
      failures++; $display("FAIL abort_stop_write actual_addr=%h actual_data=%h required=200/0",
                           (wa.size() > 78) ? wa[78] : 10'h3ff, (wd.size() > 78) ? wd[78] : 32'hffff_ffff);
    end
    checks++;
    if (done_st !== 2'd2) begin failures++; $display("FAIL abort_status actual=%0d required=2", done_st); end
  endtask

  task automatic test_finished_held();
    int acc0, sc, fc;
    checks++;
    if (done_status_a !== 2'd2) begin failures++; $display("FAIL status_hold actual=%0d required=2", done_status_a); end
    sel = 0; clear_mon();
    fin = 1'b1;
    launch();
    feed(168, 1'b0, -1, acc0);
    wait_write(32'd1, 80, sc);
    repeat (30) @(negedge clk);
    checks++;
    if (done_cnt != 0 || busy_a !== 1'b1) begin
      failures++; $display("FAIL held_no_done done_cnt=%0d busy=%b required=0,1", done_cnt, busy_a);
    end
    fin = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != 0) begin failures++; $display("FAIL held_fall_no_done actual=%0d required=0", done_cnt); end
    fin = 1'b1; fc = cyc;
    wait_done(20);
    checks++;
    if (done_cyc != fc + 1 || done_st !== 2'd0) begin
      failures++; $display("FAIL held_rise_done cyc=%0d status=%0d required_cyc=%0d status=0", done_cyc, done_st, fc + 1);
    end
    @(negedge clk); fin = 1'b0;
  endtask

  task automatic test_reset_midjob();
    int acc0;
    sel = 0; clear_mon();
    launch();
    feed(10, 1'b0, -1, acc0);
    @(negedge clk); #1;
    reset_n = 1'b1;
    #1;
    checks++;
    if (job_ready_a !== 1'b1 || busy_a !== 1'b0 || done_status_a !== 2'd0) begin
      failures++; $display("FAIL midjob_reset ready=%b busy=%b status=%0d required=1,0,0", job_ready_a, busy_a, done_status_a);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (wa.size() != 10 || find_w(10'h200, 32'd0) >= 0 || done_cnt != 0) begin
      failures++; $display("FAIL midjob_no_stop writes=%0d stop=%0d done=%0d required=10,-1,0",
                           wa.size(), find_w(10'h200, 32'd0), done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_src_toggle();
`ifdef CN_SCRATCH_FILL_EN
    test_scratch_fill();
`endif
    test_timeout();
    test_abort();
    test_finished_held();
    test_reset_midjob();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
